// File: rtl/store_buffer_pkg.sv
// -----------------------------------------------------------------------------
// store_buffer_pkg
// Shared types and default widths for the store buffer slice.
//   drain_state_e : drain FSM states (LAZY waits for the high-water mark,
//                   SYNC drains unconditionally until empty)
//   SB_*_W        : default data / address / decoded-index widths
//   sb_entry_t    : one buffered store {addr, data}, sized by the defaults
// -----------------------------------------------------------------------------
package store_buffer_pkg;

    localparam int SB_DATA_W = 20;
    localparam int SB_ADDR_W = 20;
    localparam int SB_IDX_W  = 5;

    typedef enum logic {
        LAZY = 1'b0,
        SYNC = 1'b1
    } drain_state_e;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// -----------------------------------------------------------------------------
// store_buffer_if
// Bundles the execute-side store/load ports, the data-memory write port and
// the sync handshake of the store buffer.
//   master : execute / memory side (drives stores, loads, mem_busy, sync_req)
//   slave  : the store buffer (drives st_ready, forwarding, mem_*, sync_done,
//            count)
// -----------------------------------------------------------------------------
interface store_buffer_if
    import store_buffer_pkg::*;
#(
    parameter int DATA_W = SB_DATA_W,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_ready;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_hit;
    logic [DATA_W-1:0] ld_data;
    logic              mem_busy;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              sync_req;
    logic              sync_done;
    logic [CNT_W-1:0]  count;

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_busy, sync_req,
        input  st_ready, ld_hit, ld_data, mem_wr, mem_addr, mem_wdata, sync_done, count
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_busy, sync_req,
        output st_ready, ld_hit, ld_data, mem_wr, mem_addr, mem_wdata, sync_done, count
    );

endinterface

// File: rtl/store_buffer_match.sv
// -----------------------------------------------------------------------------
// sb_match
// Combinational youngest-match search over the circular buffer.
//   valid_i  : per-slot occupancy
//   idx_i    : per-slot decoded address index
//   head_i   : slot of the oldest entry
//   ld_idx_i : decoded index of the load
//   hit_o    : some valid slot matches
//   slot_o   : youngest matching slot (closest to tail)
// -----------------------------------------------------------------------------
module sb_match #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 5,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] valid_i,
    input  logic [IDX_W-1:0] idx_i [DEPTH],
    input  logic [PTR_W-1:0] head_i,
    input  logic [IDX_W-1:0] ld_idx_i,
    output logic             hit_o,
    output logic [PTR_W-1:0] slot_o
);

    logic [PTR_W-1:0] slot;

    // Walk from oldest to youngest; a later match overrides an earlier one,
    // so the youngest match is what remains.
    always_comb begin
        hit_o  = 1'b0;
        slot_o = '0;
        slot   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_i + PTR_W'(k);
            if (valid_i[slot] && (idx_i[slot] == ld_idx_i)) begin
                hit_o  = 1'b1;
                slot_o = slot;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
// Write-posting buffer between execute and data memory. Stores are queued in
// a circular FIFO, drained into the memory write port when it is free, and
// forwarded to younger loads.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, discards all buffered stores
//   sb    : store_buffer_if.slave (store push, load forward, memory write
//           port, sync request/done, occupancy)
// Entry width follows the package default widths.
// -----------------------------------------------------------------------------
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DATA_W = SB_DATA_W,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int IDX_W  = SB_IDX_W,
    parameter int DEPTH  = 4,
    parameter int HWM    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    store_buffer_if.slave sb
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t        entries_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    drain_state_e     state_q, state_d;
    logic             sync_done_q, sync_done_d;

    logic             drain_en;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] valid;
    logic [IDX_W-1:0] idx_vec [DEPTH];
    logic             hit;
    logic [PTR_W-1:0] hit_slot;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^sb.ld_addr[ADDR_W-1:IDX_W];

    // Occupancy is derived from head/count: a slot is live when its distance
    // from the head is below the count.
    always_comb begin
        logic [PTR_W-1:0] off;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off        = PTR_W'(i) - head_q;
            valid[i]   = {1'b0, off} < count_q;
            idx_vec[i] = entries_q[i].addr[IDX_W-1:0];
        end
    end

    sb_match #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_match (
        .valid_i  (valid),
        .idx_i    (idx_vec),
        .head_i   (head_q),
        .ld_idx_i (sb.ld_addr[IDX_W-1:0]),
        .hit_o    (hit),
        .slot_o   (hit_slot)
    );

    assign drain_en     = (state_q == SYNC) || (count_q >= CNT_W'(HWM));
    assign pop          = (count_q != '0) && !sb.mem_busy && drain_en;
    assign push         = sb.st_valid && sb.st_ready;

    assign sb.mem_wr    = pop;
    assign sb.st_ready  = (count_q < CNT_W'(DEPTH)) || pop;
    assign sb.mem_addr  = (count_q != '0) ? entries_q[head_q].addr : '0;
    assign sb.mem_wdata = (count_q != '0) ? entries_q[head_q].data : '0;
    assign sb.ld_hit    = sb.ld_valid && hit;
    assign sb.ld_data   = (sb.ld_valid && hit) ? entries_q[hit_slot].data : '0;
    assign sb.sync_done = sync_done_q;
    assign sb.count     = count_q;

    assign head_d  = pop  ? head_q + PTR_W'(1) : head_q;
    assign tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
    assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // SYNC stays until the buffer is seen empty, then reports completion on
    // the following cycle; a request while already syncing is absorbed.
    always_comb begin
        state_d     = state_q;
        sync_done_d = 1'b0;
        case (state_q)
            LAZY: begin
                if (sb.sync_req) begin
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (count_q == '0) begin
                    state_d     = LAZY;
                    sync_done_d = 1'b1;
                end
            end
            default: state_d = LAZY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            state_q     <= LAZY;
            sync_done_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            state_q     <= state_d;
            sync_done_q <= sync_done_d;
        end
    end

    // Entry storage carries no reset; liveness is tracked by head/count only.
    always_ff @(posedge clk) begin
        if (push) begin
            entries_q[tail_q].addr <= sb.st_addr;
            entries_q[tail_q].data <= sb.st_data;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DATA_W = 20;
    localparam int ADDR_W = 20;
    localparam int IDX_W  = 5;
    localparam int DEPTH  = 4;
    localparam int HWM    = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    store_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) sb ();

    store_buffer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W),
        .DEPTH  (DEPTH),
        .HWM    (HWM)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sb)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t mq[$];
    bit   m_sync = 0;
    bit   m_done = 0;

    always @(negedge clk) begin
        int                cnt;
        bit                drain, wr, rdy, hit;
        logic [DATA_W-1:0] fd, ed;
        logic [ADDR_W-1:0] ea;
        if (!rst_n) begin
            mq.delete();
            m_sync = 0;
            m_done = 0;
        end
        cnt   = mq.size();
        drain = m_sync || (cnt >= HWM);
        wr    = (cnt != 0) && !sb.mem_busy && drain;
        rdy   = (cnt < DEPTH) || wr;
        ea    = (cnt != 0) ? mq[0].a : '0;
        ed    = (cnt != 0) ? mq[0].d : '0;
        hit   = 0;
        fd    = '0;
        if (sb.ld_valid) begin
            for (int k = cnt - 1; k >= 0; k--) begin
                if (mq[k].a[IDX_W-1:0] == sb.ld_addr[IDX_W-1:0]) begin
                    hit = 1;
                    fd  = mq[k].d;
                    break;
                end
            end
        end
        check("count",     sb.count,     cnt);
        check("st_ready",  sb.st_ready,  rdy);
        check("mem_wr",    sb.mem_wr,    wr);
        check("mem_addr",  sb.mem_addr,  ea);
        check("mem_wdata", sb.mem_wdata, ed);
        check("ld_hit",    sb.ld_hit,    hit);
        check("ld_data",   sb.ld_data,   fd);
        check("sync_done", sb.sync_done, m_done);
        if (rst_n) begin
            if (wr) void'(mq.pop_front());
            if (sb.st_valid && rdy) mq.push_back('{sb.st_addr, sb.st_data});
            if (!m_sync) begin
                m_done = 0;
                if (sb.sync_req) m_sync = 1;
            end else begin
                m_done = (cnt == 0);
                if (cnt == 0) m_sync = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic idle();
        sb.st_valid = 1'b0;
        sb.st_addr  = '0;
        sb.st_data  = '0;
        sb.ld_valid = 1'b0;
        sb.ld_addr  = '0;
        sb.mem_busy = 1'b0;
        sb.sync_req = 1'b0;
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        sb.st_valid = 1'b1;
        sb.st_addr  = a;
        sb.st_data  = d;
        step();
        sb.st_valid = 1'b0;
    endtask

    task automatic sync_drain();
        bit seen;
        seen = 0;
        sb.mem_busy = 1'b0;
        sb.sync_req = 1'b1;
        step();
        sb.sync_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            neg();
            if (sb.sync_done) begin
                seen = 1;
                break;
            end
            step();
        end
        check("sync_drain_done", seen, 1);
        check("sync_drain_count", sb.count, 0);
        step();
    endtask

    initial begin
        bit acc;
        idle();

        // reset state
        neg();
        check("rst_count", sb.count, 0);
        check("rst_st_ready", sb.st_ready, 1);
        check("rst_mem_wr", sb.mem_wr, 0);
        check("rst_mem_addr", sb.mem_addr, 0);
        check("rst_sync_done", sb.sync_done, 0);
        step();
        rst_n = 1'b1;
        step();

        // lazy drain at the high-water mark
        push(20'd1, 20'hA);
        push(20'd2, 20'hB);
        push(20'd3, 20'hC);
        neg();
        check("hwm_count", sb.count, 3);
        check("hwm_mem_wr", sb.mem_wr, 1);
        check("hwm_mem_addr", sb.mem_addr, 1);
        check("hwm_mem_wdata", sb.mem_wdata, 20'hA);
        step();
        neg();
        check("below_hwm_count", sb.count, 2);
        check("below_hwm_mem_wr", sb.mem_wr, 0);
        step();
        sync_drain();

        // full buffer, held store, push+pop while full
        sb.mem_busy = 1'b1;
        for (int i = 0; i < 4; i++) push(ADDR_W'(32'h10 + i), DATA_W'(32'h100 + i));
        neg();
        check("full_count", sb.count, 4);
        check("full_st_ready", sb.st_ready, 0);
        sb.st_valid = 1'b1;
        sb.st_addr  = 20'h14;
        sb.st_data  = 20'h104;
        step();
        neg();
        check("held_count", sb.count, 4);
        step();
        sb.mem_busy = 1'b0;
        neg();
        check("full_pop_mem_wr", sb.mem_wr, 1);
        check("full_pop_st_ready", sb.st_ready, 1);
        step();
        sb.st_valid = 1'b0;
        neg();
        check("pushpop_count", sb.count, 4);
        check("pushpop_mem_addr", sb.mem_addr, 20'h11);
        step();
        sync_drain();

        // youngest-match forwarding on aliased index
        push(20'h5, 20'h11);
        push(20'h25, 20'h22);
        sb.ld_valid = 1'b1;
        sb.ld_addr  = 20'h5;
        neg();
        check("fwd_hit", sb.ld_hit, 1);
        check("fwd_data", sb.ld_data, 20'h22);
        step();
        sb.ld_addr = 20'h6;
        neg();
        check("fwd_miss_hit", sb.ld_hit, 0);
        check("fwd_miss_data", sb.ld_data, 0);
        step();
        sb.ld_valid = 1'b0;
        sync_drain();

        // sync with one entry, then sync while empty
        push(20'h9, 20'h33);
        sb.sync_req = 1'b1;
        step();
        sb.sync_req = 1'b0;
        neg();
        check("sync1_mem_wr", sb.mem_wr, 1);
        check("sync1_done_early", sb.sync_done, 0);
        step();
        neg();
        check("sync1_count", sb.count, 0);
        check("sync1_done_at_empty", sb.sync_done, 0);
        step();
        neg();
        check("sync1_done", sb.sync_done, 1);
        step();
        neg();
        check("sync1_done_pulse", sb.sync_done, 0);
        step();
        sb.sync_req = 1'b1;
        step();
        sb.sync_req = 1'b0;
        neg();
        check("sync0_done_early", sb.sync_done, 0);
        step();
        neg();
        check("sync0_done", sb.sync_done, 1);
        step();

        // reset while syncing
        sb.mem_busy = 1'b1;
        push(20'h40, 20'h1);
        push(20'h41, 20'h2);
        sb.sync_req = 1'b1;
        step();
        sb.sync_req = 1'b0;
        sb.mem_busy = 1'b0;
        neg();
        check("rsync_mem_wr", sb.mem_wr, 1);
        step();
        check("rsync_pre_mem_wr", sb.mem_wr, 1);
        rst_n = 1'b0;
        #1;
        check("rsync_async_mem_wr", sb.mem_wr, 0);
        check("rsync_async_count", sb.count, 0);
        step();
        rst_n = 1'b1;
        neg();
        check("rsync_after_count", sb.count, 0);
        step();
        push(20'h50, 20'h3);
        neg();
        check("rsync_lazy_mem_wr", sb.mem_wr, 0);
        step();
        sync_drain();

        // same-cycle push and load are not forwarded
        sb.st_valid = 1'b1;
        sb.st_addr  = 20'h7;
        sb.st_data  = 20'h77;
        sb.ld_valid = 1'b1;
        sb.ld_addr  = 20'h7;
        neg();
        check("samecyc_hit", sb.ld_hit, 0);
        step();
        sb.st_valid = 1'b0;
        neg();
        check("nextcyc_hit", sb.ld_hit, 1);
        check("nextcyc_data", sb.ld_data, 20'h77);
        step();
        idle();
        sync_drain();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            neg();
            acc = sb.st_valid && sb.st_ready;
            step();
            if (!sb.st_valid || acc) begin
                sb.st_valid = ($urandom_range(0, 1) == 1);
                sb.st_addr  = ADDR_W'($urandom_range(0, 3) * 32 + $urandom_range(0, 7));
                sb.st_data  = DATA_W'($urandom);
            end
            sb.ld_valid = ($urandom_range(0, 9) < 6);
            sb.ld_addr  = ADDR_W'($urandom_range(0, 3) * 32 + $urandom_range(0, 7));
            sb.mem_busy = ($urandom_range(0, 9) < 3);
            sb.sync_req = ($urandom_range(0, 49) == 0);
        end
        neg();
        step();
        idle();
        step();
        sync_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Write-posting buffer between the execute stage and the data memory. It accepts stores from execute and holds them in a small FIFO. It drains them into the memory's single write port when that port is free, and forwards buffered data to younger loads so they never read stale memory. It drives the data memory's write enable, address and write data directly; loads still go to the memory, and this block only supplies forwarded data.

## Interface
Parameters:
- `DATA_W`, 20, data word width
- `ADDR_W`, 20, address width as delivered by execute
- `IDX_W`, 5, address bits actually decoded by data memory (32 words); used for matching
- `DEPTH`, 4, buffer entries; power of two, at least 2
- `HWM`, 3, occupancy at or above which lazy draining starts

Ports:
- `clk` in 1: rising-edge clock
- `rst_n` in 1: reset; one clock, reset is asynchronous and active-low
- `st_valid` in 1: execute presents a store
- `st_addr` in ADDR_W: store address
- `st_data` in DATA_W: store data
- `st_ready` out 1: store accepted this cycle when high together with `st_valid`
- `ld_valid` in 1: execute presents a load
- `ld_addr` in ADDR_W: load address
- `ld_hit` out 1: a buffered store matches the load
- `ld_data` out DATA_W: data of the youngest matching entry; 0 when no hit
- `mem_busy` in 1: memory port is used by a load this cycle
- `mem_wr` out 1: connects to data memory write enable
- `mem_addr` out ADDR_W: drain address
- `mem_wdata` out DATA_W: drain data
- `sync_req` in 1: single-cycle pulse requesting a full drain (fence or halt)
- `sync_done` out 1: single-cycle pulse when a requested drain completes
- `count` out log2(DEPTH)+1: current occupancy

## Operation
- Storage is a circular FIFO with head (oldest) and tail pointers. Pointers wrap modulo DEPTH; `count` spans 0..DEPTH.
- Push: occurs when `st_valid && st_ready`. Address and data are written at the tail.
- Pop: occurs when `mem_wr` is high. The head is written to memory on the same rising edge.
- `st_ready = (count < DEPTH) || mem_wr`. When full, a push is allowed in the same cycle as a pop, and `count` stays unchanged.
- Simultaneous push and pop at any occupancy leaves `count` unchanged.
- `mem_wr = (count != 0) && !mem_busy && drain_enable`. `mem_addr` and `mem_wdata` always show the head entry; both are 0 when empty.
- Forwarding: compare `ld_addr[IDX_W-1:0]` against every valid entry's `addr[IDX_W-1:0]`. The youngest match (closest to tail) wins.
  - A store being pushed in the same cycle is not forwarded.
  - The entry being popped in the same cycle still forwards.
- Drain FSM:
  - LAZY: `drain_enable = (count >= HWM)`. `sync_req` moves to SYNC.
  - SYNC: `drain_enable = 1`. When `count` reaches 0, go to LAZY and pulse `sync_done` for one cycle.
    - If the buffer is empty when `sync_req` arrives, go from SYNC to LAZY on the next edge and pulse `sync_done` then.
  - `sync_req` while already in SYNC is ignored.
  - Stores are still accepted during SYNC. Execute must stall its own pushes if it needs the buffer empty.
- Overflow: `st_valid` with `st_ready` low is not accepted. Upstream holds the store unchanged until accepted.

## Timing
- Reset (asynchronous, `rst_n` low):
  - pointers 0, `count` 0, state LAZY, all entries invalid
  - `st_ready` 1, `mem_wr` 0, `mem_addr` 0, `mem_wdata` 0, `ld_hit` 0, `ld_data` 0, `sync_done` 0
- Reset mid-drain discards all buffered stores. `mem_wr` falls immediately, not at the next edge.
- Push-to-visible: a store accepted at edge N forwards to loads from cycle N+1 onward.
- Drain latency: at least 1 cycle after push, gated by HWM or SYNC and by `mem_busy`.
- `ld_hit`, `ld_data`, `st_ready` and `mem_*` are combinational from state and inputs. `sync_done` is registered.

## Structure
- Package `store_buffer_pkg` holds:
  - drain FSM state enum (LAZY, SYNC)
  - default width constants: DATA_W 20, ADDR_W 20, IDX_W 5
  - entry struct {addr, data}
- Sub-module `sb_match`: combinational youngest-match priority search over DEPTH entries. Inputs: valid vector, index vector, head pointer, load index. Outputs: hit flag and hit slot.

## Test plan
- Reset then idle: expect `count`=0, `st_ready`=1, `mem_wr`=0. Push 3 stores (addr 1,2,3; data 0xA,0xB,0xC) with `mem_busy`=0: `mem_wr` rises once `count`=3, writes addr 1 data 0xA, then `count` goes back below HWM.
- Fill to 4 with `mem_busy`=1: `st_ready` stays 1 because `count` < DEPTH. Fifth store with `mem_busy`=1: `st_ready`=0, store held. Drop `mem_busy`: push and pop happen together, `count` stays 4.
- Stores to addr 5 with data 0x11, then to addr 0x25 (same index) with data 0x22; load addr 5: `ld_hit`=1, `ld_data`=0x22. Load addr 6: `ld_hit`=0, `ld_data`=0.
- One store buffered, `sync_req` pulse: state goes to SYNC, the entry drains, `sync_done` pulses one cycle after `count` reaches 0. `sync_req` while empty: `sync_done` on the next edge.
- `rst_n` asserted low while SYNC is draining 2 entries: `mem_wr` drops immediately. After release, `count`=0 and state is LAZY.
- Same-cycle push to addr 7 and load of addr 7: `ld_hit`=0. Next cycle, load addr 7: `ld_hit`=1.
